hazard_id_ex_stage: RTL and testbench
=====================================

Name: hazard_id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline. It captures the decode-stage control word produced by the controller, plus the operands and register specifiers.
- It contains the load-use and branch-in-ID hazard detection logic. Bubbles are inserted into EX, PC and IF/ID writes are frozen, and branch/jump redirects are gated while a stall is active.
- Sits between the ID stage (controller, register file, sign extender) and the EX stage.

Parameters:
- DATA_W, 32, operand/immediate width.
- REG_W, 5, register specifier width.
- FUNC_W, 6, ALU function code width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_memRead, id_memWrite, id_aluSrc, id_regDst, id_regWrite, id_memToReg, id_immediate  input  1 each  controller outputs.
- id_beq, id_bne, id_j  input  1 each  controller branch/jump flags.
- id_PCSrc  input  2  controller PC select: 00 seq, 01 branch, 10 jump.
- id_func  input  FUNC_W  controller funcOut.
- id_readData1, id_readData2, id_imm  input  DATA_W  register file outputs and extended immediate.
- id_rs, id_rt, id_rd  input  REG_W  instruction fields.
- mem_memRead  input  1  memRead of the instruction in EX/MEM.
- mem_writeReg  input  REG_W  destination of the instruction in EX/MEM.
- ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite, ex_memToReg, ex_immediate  output  1 each  registered controls.
- ex_func  output  FUNC_W  registered ALU function.
- ex_readData1, ex_readData2, ex_imm  output  DATA_W  registered operands.
- ex_rs, ex_rt  output  REG_W  registered specifiers (for forwarding).
- ex_writeReg  output  REG_W  registered destination = id_regDst ? id_rd : id_rt.
- pcWrite  output  1  PC load enable.
- ifidWrite  output  1  IF/ID load enable.
- ifidFlush  output  1  IF/ID flush (taken branch/jump).
- pcSrcOut  output  2  gated PC select to the PC mux.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=1 at posedge): all ex_* registers are 0, ex_func is 6'b000000 (NOP function), and stall_count is 0.
- While rst=1, combinational outputs are forced: pcWrite=1, ifidWrite=1, ifidFlush=0, pcSrcOut=00.
- match(r) = (r != 0) && (r == id_rs || r == id_rt). Both fields are compared for every opcode (conservative detection).
- H1, load-use: ex_memRead && match(ex_writeReg).
- H2, branch after ALU op: (id_beq || id_bne) && ex_regWrite && !ex_memRead && match(ex_writeReg).
- H3, branch after load, second cycle: (id_beq || id_bne) && mem_memRead && match(mem_writeReg).
- stall = !rst && (H1 || H2 || H3). It is purely combinational from the registered EX state and the current ID/MEM inputs.
- J never raises a hazard.
- pcWrite = ifidWrite = !stall.
- pcSrcOut = stall ? 00 : id_PCSrc. A branch evaluated on a stale equalRegs must not redirect.
- ifidFlush = !stall && (id_PCSrc != 00).
- Posedge, stall=1: a bubble is loaded. All ex_* controls become 0 and ex_func becomes 000000. ex_readData1/2, ex_imm, ex_rs, ex_rt and ex_writeReg are still captured from the inputs.
- Posedge, stall=0: all id_* fields are captured, with 1-cycle latency.
- The branch/jump flags and PCSrc are not propagated to EX; branches resolve in ID.
- Load followed by a dependent branch gives 2 consecutive stall cycles: H1 in the first cycle, H3 in the second.
- ALU op followed by a dependent branch gives 1 stall cycle (H2).
- stall_count increments on every posedge with stall=1 and rst=0. It saturates at all-ones and never wraps.
- Reset asserted mid-stall: the next edge loads reset values and no bubble state persists.

Decomposition:
- Shared package holds:
  - Opcode constants (LW, SW, BEQ, BNE, ADDI, ANDI, RTYPE, J, NOP).
  - Function constants ADDF, ANDF, NOPF.
  - PCSrc encodings PC_SEQ=00, PC_BR=01, PC_JMP=10.
  - A packed control-word typedef covering the EX/MEM/WB control bits plus func.
- One natural sub-module: hazard_detect. It is combinational, computes H1/H2/H3 and stall, and is instantiated by the register stage.

Test Plan:
- Reset check: drive rst=1 with id_regWrite=1 and id_func=100000 -> after the edge all ex_* are 0, ex_func=000000, stall_count=0, pcWrite=1.
- Load-use: lw $2 (ex_memRead=1, ex_writeReg=2), then add with id_rs=2 -> stall=1 for exactly 1 cycle, pcWrite=0, bubble in EX (ex_regWrite=0), add captured on the following cycle, stall_count=1.
- Load then dependent beq:
  - First cycle: ex_writeReg=3 and ex_memRead=1, with id_beq=1, id_rt=3 and id_PCSrc=01 -> stall for 2 cycles (H1 then H3), pcSrcOut=00 and ifidFlush=0 throughout.
  - Third cycle: pcSrcOut=01 and ifidFlush=1.
- ALU then dependent bne: ex_regWrite=1, ex_writeReg=4, id_bne=1, id_rs=4 -> 1 stall cycle, then pcSrcOut follows id_PCSrc.
- Register $0 and jump: ex_memRead=1 with ex_writeReg=0 and id_rs=0 -> no stall. Independently, id_j=1 with id_PCSrc=10 -> pcSrcOut=10 and ifidFlush=1 in the same cycle.
- Saturation: set CNT_W=2 and force 5 consecutive stall cycles -> stall_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_id_ex_stage_pkg.sv
// Shared encodings and the EX/MEM/WB control word for the ID/EX stage.
package hazard_id_ex_stage_pkg;

   localparam int unsigned OP_W      = 6;
   localparam int unsigned FUNC_BITS = 6;
   localparam int unsigned PCSRC_W   = 2;

   // Opcodes
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_NOP   = 6'b000000;

   // ALU function codes
   localparam logic [FUNC_BITS-1:0] FUNC_ADDF = 6'b100000;
   localparam logic [FUNC_BITS-1:0] FUNC_ANDF = 6'b100100;
   localparam logic [FUNC_BITS-1:0] FUNC_NOPF = 6'b000000;

   // PC mux select
   localparam logic [PCSRC_W-1:0] PC_SEQ = 2'b00;
   localparam logic [PCSRC_W-1:0] PC_BR  = 2'b01;
   localparam logic [PCSRC_W-1:0] PC_JMP = 2'b10;

   // Control bits carried from ID into EX (branch/jump flags resolve in ID)
   typedef struct packed {
      logic                 mem_read;
      logic                 mem_write;
      logic                 alu_src;
      logic                 reg_write;
      logic                 mem_to_reg;
      logic                 immediate;
      logic [FUNC_BITS-1:0] func;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{
      mem_read: 1'b0, mem_write: 1'b0, alu_src: 1'b0, reg_write: 1'b0,
      mem_to_reg: 1'b0, immediate: 1'b0, func: FUNC_NOPF
   };

endpackage

// File: rtl/hazard_id_ex_stage_hazard_detect.sv
// Load-use and branch-in-ID hazard detection; purely combinational.
module hazard_detect #(
   parameter int unsigned REG_W = 5
) (
   input  logic             rst,
   input  logic             ex_memRead,
   input  logic             ex_regWrite,
   input  logic [REG_W-1:0] ex_writeReg,
   input  logic             mem_memRead,
   input  logic [REG_W-1:0] mem_writeReg,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_beq,
   input  logic             id_bne,
   output logic             stall_c
);

   logic match_ex;
   logic match_mem;
   logic is_branch;
   logic h1_load_use;
   logic h2_branch_alu;
   logic h3_branch_load;

   // Both source fields are compared regardless of opcode; $0 never matches
   always_comb begin
      match_ex       = 1'b0;
      match_mem      = 1'b0;
      is_branch      = 1'b0;
      h1_load_use    = 1'b0;
      h2_branch_alu  = 1'b0;
      h3_branch_load = 1'b0;
      stall_c        = 1'b0;

      match_ex  = (ex_writeReg != '0) && ((ex_writeReg == id_rs) || (ex_writeReg == id_rt));
      match_mem = (mem_writeReg != '0) && ((mem_writeReg == id_rs) || (mem_writeReg == id_rt));
      is_branch = id_beq || id_bne;

      h1_load_use    = ex_memRead && match_ex;
      h2_branch_alu  = is_branch && ex_regWrite && !ex_memRead && match_ex;
      h3_branch_load = is_branch && mem_memRead && match_mem;

      stall_c = !rst && (h1_load_use || h2_branch_alu || h3_branch_load);
   end

endmodule

// File: rtl/hazard_id_ex_stage.sv
// ID/EX pipeline register with hazard stall, bubble insertion and redirect gating.
module hazard_id_ex_stage
   import hazard_id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned FUNC_W = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_memRead,
   input  logic              id_memWrite,
   input  logic              id_aluSrc,
   input  logic              id_regDst,
   input  logic              id_regWrite,
   input  logic              id_memToReg,
   input  logic              id_immediate,
   input  logic              id_beq,
   input  logic              id_bne,
   input  logic              id_j,
   input  logic [1:0]        id_PCSrc,
   input  logic [FUNC_W-1:0] id_func,
   input  logic [DATA_W-1:0] id_readData1,
   input  logic [DATA_W-1:0] id_readData2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              mem_memRead,
   input  logic [REG_W-1:0]  mem_writeReg,
   output logic              ex_memRead,
   output logic              ex_memWrite,
   output logic              ex_aluSrc,
   output logic              ex_regWrite,
   output logic              ex_memToReg,
   output logic              ex_immediate,
   output logic [FUNC_W-1:0] ex_func,
   output logic [DATA_W-1:0] ex_readData1,
   output logic [DATA_W-1:0] ex_readData2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_writeReg,
   output logic              pcWrite,
   output logic              ifidWrite,
   output logic              ifidFlush,
   output logic [1:0]        pcSrcOut,
   output logic [CNT_W-1:0]  stall_count
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;
   logic  stall_c;
   logic  jmp_unused;

   // Jumps are resolved in ID and never create a data hazard
   assign jmp_unused = id_j;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .rst          (rst),
      .ex_memRead   (ctrl_q.mem_read),
      .ex_regWrite  (ctrl_q.reg_write),
      .ex_writeReg  (ex_writeReg),
      .mem_memRead  (mem_memRead),
      .mem_writeReg (mem_writeReg),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_beq       (id_beq),
      .id_bne       (id_bne),
      .stall_c      (stall_c)
   );

   // Pack the decode control word; a stall replaces it with a bubble
   always_comb begin
      ctrl_d            = CTRL_BUBBLE;
      ctrl_d.mem_read   = id_memRead;
      ctrl_d.mem_write  = id_memWrite;
      ctrl_d.alu_src    = id_aluSrc;
      ctrl_d.reg_write  = id_regWrite;
      ctrl_d.mem_to_reg = id_memToReg;
      ctrl_d.immediate  = id_immediate;
      ctrl_d.func       = FUNC_BITS'(id_func);
      if (stall_c) begin
         ctrl_d = CTRL_BUBBLE;
      end
   end

   // Pipeline register; operands and specifiers are captured even during a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q       <= CTRL_BUBBLE;
         ex_readData1 <= '0;
         ex_readData2 <= '0;
         ex_imm       <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_writeReg  <= '0;
         stall_count  <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         ex_readData1 <= id_readData1;
         ex_readData2 <= id_readData2;
         ex_imm       <= id_imm;
         ex_rs        <= id_rs;
         ex_rt        <= id_rt;
         ex_writeReg  <= id_regDst ? id_rd : id_rt;
         if (stall_c && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

   assign ex_memRead   = ctrl_q.mem_read;
   assign ex_memWrite  = ctrl_q.mem_write;
   assign ex_aluSrc    = ctrl_q.alu_src;
   assign ex_regWrite  = ctrl_q.reg_write;
   assign ex_memToReg  = ctrl_q.mem_to_reg;
   assign ex_immediate = ctrl_q.immediate;
   assign ex_func      = FUNC_W'(ctrl_q.func);

   // Freeze fetch and suppress redirects while a stall or reset is active
   always_comb begin
      pcWrite   = 1'b1;
      ifidWrite = 1'b1;
      ifidFlush = 1'b0;
      pcSrcOut  = PC_SEQ;
      if (!rst) begin
         pcWrite   = !stall_c;
         ifidWrite = !stall_c;
         ifidFlush = !stall_c && (id_PCSrc != PC_SEQ);
         pcSrcOut  = stall_c ? PC_SEQ : id_PCSrc;
      end
   end

endmodule

// File: tb/tb_hazard_id_ex_stage.sv
// Directed scoreboard bench for the ID/EX hazard stage.
module tb_hazard_id_ex_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned FUNC_W = 6;
   localparam int unsigned CNT_W  = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] P_SEQ = 2'b00;
   localparam logic [1:0] P_BR  = 2'b01;
   localparam logic [1:0] P_JMP = 2'b10;
   localparam logic [FUNC_W-1:0] F_ADD = 6'b100000;

   logic clk, rst;
   logic id_memRead, id_memWrite, id_aluSrc, id_regDst, id_regWrite, id_memToReg, id_immediate;
   logic id_beq, id_bne, id_j;
   logic [1:0] id_PCSrc;
   logic [FUNC_W-1:0] id_func;
   logic [DATA_W-1:0] id_readData1, id_readData2, id_imm;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic mem_memRead;
   logic [REG_W-1:0] mem_writeReg;
   logic ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite, ex_memToReg, ex_immediate;
   logic [FUNC_W-1:0] ex_func;
   logic [DATA_W-1:0] ex_readData1, ex_readData2, ex_imm;
   logic [REG_W-1:0] ex_rs, ex_rt, ex_writeReg;
   logic pcWrite, ifidWrite, ifidFlush;
   logic [1:0] pcSrcOut;
   logic [CNT_W-1:0] stall_count;

   typedef struct packed {
      logic [5:0]          ctrl;
      logic [FUNC_W-1:0]   func;
      logic [3*DATA_W-1:0] data;
      logic [3*REG_W-1:0]  spec;
      logic [CNT_W-1:0]    cnt;
   } exp_t;

   exp_t q[$];
   logic [CNT_W-1:0] cnt_m;
   int checks;
   int errors;

   hazard_id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .FUNC_W(FUNC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc),
      .id_regDst(id_regDst), .id_regWrite(id_regWrite), .id_memToReg(id_memToReg),
      .id_immediate(id_immediate), .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j),
      .id_PCSrc(id_PCSrc), .id_func(id_func),
      .id_readData1(id_readData1), .id_readData2(id_readData2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .mem_memRead(mem_memRead), .mem_writeReg(mem_writeReg),
      .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc),
      .ex_regWrite(ex_regWrite), .ex_memToReg(ex_memToReg), .ex_immediate(ex_immediate),
      .ex_func(ex_func), .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_writeReg(ex_writeReg),
      .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
      .pcSrcOut(pcSrcOut), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_memRead = 1'b0; id_memWrite = 1'b0; id_aluSrc = 1'b0; id_regDst = 1'b0;
      id_regWrite = 1'b0; id_memToReg = 1'b0; id_immediate = 1'b0;
      id_beq = 1'b0; id_bne = 1'b0; id_j = 1'b0; id_PCSrc = P_SEQ; id_func = '0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      mem_memRead = 1'b0; mem_writeReg = '0;
   endtask

   // Drive one cycle: check combinational outputs, queue the EX expectation, check after the edge
   task automatic step(input string tag, input bit es, input logic [1:0] ep, input bit ef);
      exp_t e, got;
      id_readData1 = $urandom;
      id_readData2 = $urandom;
      id_imm       = $urandom;
      #1;
      chk({tag, ".pcWrite"},   128'(pcWrite),   128'(!es));
      chk({tag, ".ifidWrite"}, 128'(ifidWrite), 128'(!es));
      chk({tag, ".pcSrcOut"},  128'(pcSrcOut),  128'(ep));
      chk({tag, ".ifidFlush"}, 128'(ifidFlush), 128'(ef));
      if (rst) begin
         e = '0;
         cnt_m = '0;
      end else begin
         e.ctrl = es ? 6'b0 : {id_memRead, id_memWrite, id_aluSrc, id_regWrite, id_memToReg, id_immediate};
         e.func = es ? '0 : id_func;
         e.data = {id_readData1, id_readData2, id_imm};
         e.spec = {id_rs, id_rt, id_regDst ? id_rd : id_rt};
         if (es && cnt_m != CNT_MAX) cnt_m = cnt_m + CNT_W'(1);
         e.cnt = cnt_m;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      got.ctrl = {ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite, ex_memToReg, ex_immediate};
      got.func = ex_func;
      got.data = {ex_readData1, ex_readData2, ex_imm};
      got.spec = {ex_rs, ex_rt, ex_writeReg};
      got.cnt  = stall_count;
      e = q.pop_front();
      chk({tag, ".ex_ctrl"},     128'(got.ctrl), 128'(e.ctrl));
      chk({tag, ".ex_func"},     128'(got.func), 128'(e.func));
      chk({tag, ".ex_data"},     128'(got.data), 128'(e.data));
      chk({tag, ".ex_spec"},     128'(got.spec), 128'(e.spec));
      chk({tag, ".stall_count"}, 128'(got.cnt),  128'(e.cnt));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr();
      step("rst", 1'b0, P_SEQ, 1'b0);
      rst = 1'b0;
   endtask

   task automatic drive_lw(input logic [REG_W-1:0] rt);
      clr();
      id_memRead = 1'b1; id_aluSrc = 1'b1; id_regWrite = 1'b1; id_memToReg = 1'b1;
      id_immediate = 1'b1; id_func = F_ADD; id_rs = 5'd1; id_rt = rt;
   endtask

   task automatic drive_add(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                            input logic [REG_W-1:0] rd);
      clr();
      id_regDst = 1'b1; id_regWrite = 1'b1; id_func = F_ADD;
      id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cnt_m  = '0;
      rst    = 1'b1;
      clr();
      @(negedge clk);

      // Reset with live controls and a pending branch select
      clr();
      id_regWrite = 1'b1; id_func = F_ADD; id_PCSrc = P_BR;
      step("reset", 1'b0, P_SEQ, 1'b0);
      rst = 1'b0;

      // Load-use: one bubble, then the add is captured
      do_reset();
      drive_lw(5'd2);
      step("lu_lw", 1'b0, P_SEQ, 1'b0);
      drive_add(5'd2, 5'd3, 5'd5);
      step("lu_stall", 1'b1, P_SEQ, 1'b0);
      step("lu_go", 1'b0, P_SEQ, 1'b0);

      // Load then dependent beq: H1 then H3, redirect only on the third cycle
      do_reset();
      drive_lw(5'd3);
      step("lb_lw", 1'b0, P_SEQ, 1'b0);
      clr();
      id_beq = 1'b1; id_rs = 5'd1; id_rt = 5'd3; id_PCSrc = P_BR;
      step("lb_h1", 1'b1, P_SEQ, 1'b0);
      mem_memRead = 1'b1; mem_writeReg = 5'd3;
      step("lb_h3", 1'b1, P_SEQ, 1'b0);
      mem_memRead = 1'b0;
      step("lb_go", 1'b0, P_BR, 1'b1);

      // ALU then dependent bne: single H2 stall
      do_reset();
      drive_add(5'd5, 5'd6, 5'd4);
      step("ab_add", 1'b0, P_SEQ, 1'b0);
      clr();
      id_bne = 1'b1; id_rs = 5'd4; id_rt = 5'd7; id_PCSrc = P_BR;
      step("ab_h2", 1'b1, P_SEQ, 1'b0);
      step("ab_go", 1'b0, P_BR, 1'b1);

      // Register $0 never matches; jump redirects immediately
      do_reset();
      drive_lw(5'd0);
      step("z_lw", 1'b0, P_SEQ, 1'b0);
      drive_add(5'd0, 5'd0, 5'd0);
      step("z_add", 1'b0, P_SEQ, 1'b0);
      clr();
      id_j = 1'b1; id_PCSrc = P_JMP;
      step("z_jmp", 1'b0, P_JMP, 1'b1);

      // Saturating counter: five sustained H3 stalls read 1,2,3,3,3
      do_reset();
      clr();
      id_beq = 1'b1; id_rs = 5'd1; id_rt = 5'd3; id_PCSrc = P_BR;
      mem_memRead = 1'b1; mem_writeReg = 5'd3;
      for (int i = 0; i < 5; i++) begin
         step("sat", 1'b1, P_SEQ, 1'b0);
      end

      // Reset mid-stall clears everything; branch then proceeds
      rst = 1'b1;
      step("mid_rst", 1'b0, P_SEQ, 1'b0);
      rst = 1'b0;
      mem_memRead = 1'b0;
      step("post_rst", 1'b0, P_BR, 1'b1);

      chk("queue_empty", 128'(q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
